// File: rtl/wombat_uart_rx.sv
// Oversampling UART receiver with one-deep valid/ready holding register.
// Define WOMBAT_UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module wombat_uart_rx #(
  parameter int WORD_WIDTH    = 8,
  parameter int DIVISOR       = 434,
  parameter int SAMPLE_PHASE  = 217,
  parameter int LITTLE_ENDIAN = 1,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_rx,
  output logic [WORD_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_frame_err,
  output logic                  o_parity_err,
  output logic                  o_overrun,
  output logic                  o_busy
);

  localparam int BW = $clog2(DIVISOR);
  localparam int CW = $clog2(WORD_WIDTH + 1);
  localparam logic [BW-1:0] C_PH = BW'(SAMPLE_PHASE);
  localparam logic [BW-1:0] C_LAST = BW'(DIVISOR - 1);
  localparam logic [CW-1:0] C_BLAST = CW'(WORD_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                  r_rxs_d;
  logic [BW-1:0]         r_baud;
  logic [CW-1:0]         r_bit;
  logic [WORD_WIDTH-1:0] r_shift;
  logic [WORD_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_frame_err;
  logic                  r_parity_err;
  logic                  r_overrun;

  logic                  w_rxs;
  logic                  w_phase;
  logic                  w_last;
  logic                  w_par_bad;
  logic [WORD_WIDTH-1:0] w_shift_nx;

  assign w_rxs   = r_sync[SYNC_STAGES-1];
  assign w_phase = (r_baud == C_PH);
  assign w_last  = (r_baud == C_LAST);

  always_comb begin
    w_shift_nx = r_shift;
    if (LITTLE_ENDIAN != 0)
      w_shift_nx = {w_rxs, r_shift[WORD_WIDTH-1:1]};
    else
      w_shift_nx = {r_shift[WORD_WIDTH-2:0], w_rxs};
  end

`ifdef WOMBAT_UART_RX_PARITY_EN
  logic r_par;
  assign w_par_bad = r_par ^ (^r_shift);
`else
  assign w_par_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_rxs_d      <= 1'b1;
      r_baud       <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef WOMBAT_UART_RX_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else begin
      r_rxs_d      <= w_rxs;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
      r_baud       <= w_last ? '0 : r_baud + 1'b1;
      if (r_valid && i_ready)
        r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          if (r_rxs_d && !w_rxs)
            r_state <= S_START;
        end
        S_START: begin
          if (w_phase && w_rxs) begin
            r_state <= S_IDLE;
          end else if (w_last) begin
            r_state <= S_DATA;
            r_bit   <= '0;
          end
        end
        S_DATA: begin
          if (w_phase)
            r_shift <= w_shift_nx;
          if (w_last) begin
            if (r_bit == C_BLAST) begin
`ifdef WOMBAT_UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
`ifdef WOMBAT_UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_phase)
            r_par <= w_rxs;
          if (w_last)
            r_state <= S_STOP;
        end
`endif
        S_STOP: begin
          // Leave half a bit early so a back-to-back start edge is caught.
          if (w_phase) begin
            r_state <= S_IDLE;
            if (!w_rxs)
              r_frame_err <= 1'b1;
            if (w_par_bad)
              r_parity_err <= 1'b1;
            if (w_rxs && !w_par_bad) begin
              if (r_valid && !i_ready) begin
                r_overrun <= 1'b1;
              end else begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_frame_err  = r_frame_err;
  assign o_parity_err = r_parity_err;
  assign o_overrun    = r_overrun;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_wombat_uart_rx.sv
// Scoreboard bench for wombat_uart_rx at DIVISOR=8, SAMPLE_PHASE=4.
// A second instance checks the MSB-first word ordering.
module tb_wombat_uart_rx;

  localparam int DIV = 8;
  localparam int PH  = 4;
  localparam int W   = 8;

  logic         clk = 1'b0;
  logic         i_reset;
  logic         i_rx;
  logic         i_ready;
  logic [W-1:0] o_data;
  logic         o_valid;
  logic         o_frame_err;
  logic         o_parity_err;
  logic         o_overrun;
  logic         o_busy;
  logic [W-1:0] be_data;
  logic         be_valid;
  logic         be_frame_err;
  logic         be_parity_err;
  logic         be_overrun;
  logic         be_busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_fe = 0;
  int n_pe = 0;
  int n_ov = 0;
  int n_hs = 0;
  int be_cnt = 0;
  logic [W-1:0] be_last = '0;
  logic [W-1:0] q[$];
  logic [W-1:0] exp_w;

  always #5 clk = ~clk;

  wombat_uart_rx #(
    .WORD_WIDTH(W), .DIVISOR(DIV), .SAMPLE_PHASE(PH),
    .LITTLE_ENDIAN(1), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .i_reset(i_reset), .i_rx(i_rx),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_frame_err(o_frame_err), .o_parity_err(o_parity_err),
    .o_overrun(o_overrun), .o_busy(o_busy)
  );

  wombat_uart_rx #(
    .WORD_WIDTH(W), .DIVISOR(DIV), .SAMPLE_PHASE(PH),
    .LITTLE_ENDIAN(0), .SYNC_STAGES(2)
  ) dut_be (
    .clk(clk), .i_reset(i_reset), .i_rx(i_rx),
    .o_data(be_data), .o_valid(be_valid), .i_ready(1'b1),
    .o_frame_err(be_frame_err), .o_parity_err(be_parity_err),
    .o_overrun(be_overrun), .o_busy(be_busy)
  );

  always @(negedge clk) begin
    if (!i_reset) begin
      if (o_frame_err) n_fe++;
      if (o_parity_err) n_pe++;
      if (o_overrun) n_ov++;
      if (be_valid) begin
        be_cnt++;
        be_last = be_data;
      end
      if (o_valid && i_ready) begin
        n_hs++;
        n_checks++;
        if (q.size() == 0) begin
          n_errors++;
          $display("FAIL sb_unexpected got %h want none", o_data);
        end else begin
          exp_w = q.pop_front();
          if (o_data !== exp_w) begin
            n_errors++;
            $display("FAIL sb_data got %h want %h", o_data, exp_w);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    i_rx = b;
    repeat (DIV) tick();
  endtask

  task automatic idle(input int nbits);
    i_rx = 1'b1;
    repeat (nbits * DIV) tick();
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic stop,
                            input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < W; i++) send_bit(d[i]);
`ifdef WOMBAT_UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop);
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_rx    = 1'b1;
    i_ready = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({o_data, o_valid, o_busy} !== 10'h0) begin
      n_errors++;
      $display("FAIL rst_out got %h want 0", {o_data, o_valid, o_busy});
    end
    n_checks++;
    if ({o_frame_err, o_parity_err, o_overrun} !== 3'b0) begin
      n_errors++;
      $display("FAIL rst_err got %b want 000",
               {o_frame_err, o_parity_err, o_overrun});
    end
    i_reset = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    int hs0 = n_hs;
    int fe0 = n_fe;
    int ov0 = n_ov;
    int pe0 = n_pe;
    q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(2);
    chk("basic_valid_cycles", n_hs - hs0, 1);
    chk("basic_fe", n_fe - fe0, 0);
    chk("basic_ov", n_ov - ov0, 0);
    chk("basic_pe", n_pe - pe0, 0);
    chk("basic_valid_low", int'(o_valid), 0);
  endtask

  task automatic test_endian();
    int be0 = be_cnt;
    q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b0);
    idle(2);
    chk("be_count", be_cnt - be0, 1);
    n_checks++;
    if (be_last !== 8'h80) begin
      n_errors++;
      $display("FAIL be_data got %h want 80", be_last);
    end
  endtask

  task automatic test_frame_err();
    int hs0 = n_hs;
    int fe0 = n_fe;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(2);
    chk("fe_pulse", n_fe - fe0, 1);
    chk("fe_no_valid", n_hs - hs0, 0);
    q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    idle(2);
    chk("fe_recover", n_hs - hs0, 1);
    chk("fe_recover_fe", n_fe - fe0, 1);
  endtask

  task automatic test_back_to_back();
    int hs0 = n_hs;
    int ov0 = n_ov;
    i_ready = 1'b0;
    q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'h02, 1'b1, 1'b0);
    idle(2);
    chk("ov_pulse", n_ov - ov0, 1);
    chk("ov_valid_held", int'(o_valid), 1);
    n_checks++;
    if (o_data !== 8'h01) begin
      n_errors++;
      $display("FAIL ov_data got %h want 01", o_data);
    end
    chk("ov_no_hs", n_hs - hs0, 0);
    i_ready = 1'b1;
    tick();
    tick();
    chk("ov_consumed", n_hs - hs0, 1);
    chk("ov_valid_clr", int'(o_valid), 0);
  endtask

  task automatic test_glitch();
    int hs0 = n_hs;
    int fe0 = n_fe;
    i_rx = 1'b0;
    tick();
    tick();
    idle(3);
    chk("gl_busy", int'(o_busy), 0);
    chk("gl_no_valid", n_hs - hs0, 0);
    chk("gl_no_fe", n_fe - fe0, 0);
  endtask

  task automatic test_reset_mid();
    int hs0 = n_hs;
    int fe0 = n_fe;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("rm_busy", int'(o_busy), 1);
    i_reset = 1'b1;
    #1;
    n_checks++;
    if ({o_data, o_valid, o_busy} !== 10'h0) begin
      n_errors++;
      $display("FAIL rm_out got %h want 0", {o_data, o_valid, o_busy});
    end
    i_rx = 1'b1;
    repeat (3) tick();
    i_reset = 1'b0;
    idle(2);
    q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(2);
    chk("rm_rx", n_hs - hs0, 1);
    chk("rm_fe", n_fe - fe0, 0);
  endtask

  task automatic test_parity();
`ifdef WOMBAT_UART_RX_PARITY_EN
    int hs0 = n_hs;
    int pe0 = n_pe;
    send_frame(8'h07, 1'b1, 1'b1);
    idle(2);
    chk("par_pulse", n_pe - pe0, 1);
    chk("par_drop", n_hs - hs0, 0);
    q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(2);
    chk("par_ok", n_hs - hs0, 1);
    chk("par_ok_pe", n_pe - pe0, 1);
`else
    chk("par_tied0", n_pe, 0);
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_endian();
    test_frame_err();
    test_back_to_back();
    test_glitch();
    test_reset_mid();
    test_parity();
    chk("sb_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
